// File: rtl/mdu_seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : mdu_seq_alu
// Purpose  : Multi-cycle ALU. ADD/SUB take one cycle. MUL uses shift-add and
//            DIV uses restoring division, one bit per cycle. Requests and
//            results use valid/ready handshakes. Defining MDU_SIGNED_EN adds
//            signed MUL/DIV, selected per request by is_signed.
// Revision : 1.0  initial release
// ============================================================================
module mdu_seq_alu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             div_by_zero
);

  localparam logic [2:0] c_OP_ADD = 3'd1;
  localparam logic [2:0] c_OP_SUB = 3'd2;
  localparam logic [2:0] c_OP_MUL = 3'd3;
  localparam logic [2:0] c_OP_DIV = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             is_div_q, is_div_d;
  logic             fix_q, fix_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic             zero_q, zero_d;
  logic             dbz_q, dbz_d;

  logic             w_sgn;
`ifdef MDU_SIGNED_EN
  assign w_sgn = is_signed;
`else
  logic w_unused_signed;
  assign w_sgn           = 1'b0;
  assign w_unused_signed = is_signed;
`endif

  // The iterations always run on magnitudes; signs are applied in a fix-up cycle.
  logic             w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  assign w_a_neg = w_sgn & a[WIDTH-1];
  assign w_b_neg = w_sgn & b[WIDTH-1];
  assign w_a_mag = w_a_neg ? -a : a;
  assign w_b_mag = w_b_neg ? -b : b;

  // MUL: {hi,lo} holds the partial product above the remaining multiplier bits.
  logic [WIDTH-1:0] w_addend;
  logic [WIDTH:0]   w_mul_sum;
  assign w_addend  = lo_q[0] ? dvs_q : '0;
  assign w_mul_sum = {1'b0, hi_q} + {1'b0, w_addend};

  // DIV: hi is the partial remainder, lo shifts the dividend out and the quotient in.
  logic [WIDTH:0]   w_div_shift, w_div_diff;
  logic             w_div_ok;
  assign w_div_shift = {hi_q, lo_q[WIDTH-1]};
  assign w_div_diff  = w_div_shift - {1'b0, dvs_q};
  assign w_div_ok    = ~w_div_diff[WIDTH];

  logic [WIDTH-1:0] w_it_hi, w_it_lo;
  assign w_it_hi = is_div_q ? (w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0])
                            : w_mul_sum[WIDTH:1];
  assign w_it_lo = is_div_q ? {lo_q[WIDTH-2:0], w_div_ok}
                            : {w_mul_sum[0], lo_q[WIDTH-1:1]};

  logic [2*WIDTH-1:0] w_prod_neg;
  logic [WIDTH-1:0]   w_fix_hi, w_fix_lo;
  assign w_prod_neg = -{hi_q, lo_q};
  assign w_fix_lo = is_div_q ? (neg_lo_q ? -lo_q : lo_q)
                             : (neg_lo_q ? w_prod_neg[WIDTH-1:0] : lo_q);
  assign w_fix_hi = is_div_q ? (neg_hi_q ? -hi_q : hi_q)
                             : (neg_lo_q ? w_prod_neg[2*WIDTH-1:WIDTH] : hi_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dvs_d    = dvs_q;
    is_div_d = is_div_q;
    fix_d    = fix_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    zero_d   = zero_q;
    dbz_d    = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          dbz_d    = 1'b0;
          hi_d     = '0;
          neg_lo_d = w_a_neg ^ w_b_neg;
          neg_hi_d = w_a_neg;
          fix_d    = w_sgn;
          case (op)
            c_OP_ADD: begin
              lo_d    = a + b;
              state_d = S_DONE;
            end
            c_OP_SUB: begin
              lo_d    = a - b;
              state_d = S_DONE;
            end
            c_OP_MUL: begin
              lo_d     = w_a_mag;
              dvs_d    = w_b_mag;
              is_div_d = 1'b0;
              cnt_d    = CNT_W'(WIDTH);
              state_d  = S_BUSY;
            end
            c_OP_DIV: begin
              if (b == '0) begin
                lo_d    = '1;
                hi_d    = a;
                dbz_d   = 1'b1;
                state_d = S_DONE;
              end else begin
                lo_d     = w_a_mag;
                dvs_d    = w_b_mag;
                is_div_d = 1'b1;
                cnt_d    = CNT_W'(WIDTH);
                state_d  = S_BUSY;
              end
            end
            default: begin
              lo_d    = '0;
              state_d = S_DONE;
            end
          endcase
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          lo_d    = w_fix_lo;
          hi_d    = w_fix_hi;
          state_d = S_DONE;
        end else begin
          lo_d  = w_it_lo;
          hi_d  = w_it_hi;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1) && !fix_q) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_DONE && state_q != S_DONE) begin
      zero_d = (lo_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dvs_q    <= '0;
      is_div_q <= 1'b0;
      fix_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      zero_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dvs_q    <= dvs_d;
      is_div_q <= is_div_d;
      fix_q    <= fix_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      zero_q   <= zero_d;
      dbz_q    <= dbz_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign result_lo   = lo_q;
  assign result_hi   = hi_q;
  assign zero        = zero_q;
  assign div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: doc/mdu_seq_alu.md
Name: mdu_seq_alu

Overview:
- Parametrised, multi-cycle successor to the single-cycle ALU datapath.
- Executes ADD/SUB in one cycle and MUL/DIV iteratively: shift-add multiply, restoring divide, one bit per cycle.
- Produces a double-width product, or quotient plus remainder, behind valid/ready handshakes.
- Sits between the decode/operand-fetch stage and the HI/LO / writeback logic; stalls upstream via in_ready.

Parameters:
- WIDTH, 32, operand and result width in bits (legal range 4..64).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  operation request
- in_ready  output  1  block can accept a request
- op  input  3  0 NOP, 1 ADD, 2 SUB, 3 MUL, 4 DIV; 5..7 treated as NOP
- is_signed  input  1  signed MUL/DIV select (used only with MDU_SIGNED_EN)
- a  input  WIDTH  operand A / dividend
- b  input  WIDTH  operand B / divisor
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- result_lo  output  WIDTH  sum, difference, product low half, or quotient
- result_hi  output  WIDTH  product high half or remainder; 0 for ADD/SUB/NOP
- zero  output  1  result_lo == 0
- div_by_zero  output  1  DIV issued with b == 0

Behaviour:
- Reset, synchronous:
  - state IDLE; in_ready 1; out_valid 0; result_lo, result_hi, zero, div_by_zero all 0.
  - Reset while BUSY or DONE aborts the operation and discards the pending result.
- FSM states: IDLE, BUSY, DONE.
  - in_ready = (state == IDLE). Operands and op are captured only when in_valid && in_ready.
  - IDLE accepting ADD/SUB/NOP/illegal: move to DONE next cycle with the result registered.
  - IDLE accepting MUL/DIV with b != 0: move to BUSY; counter loaded with WIDTH.
  - IDLE accepting DIV with b == 0: move directly to DONE.
  - BUSY: one iteration per cycle; counter decrements; at count 1 move to DONE with the final value registered.
  - DONE: out_valid 1; all outputs held stable until out_ready is seen, then move to IDLE.
  - No new request is accepted in DONE, so there is no same-cycle overlap.
- Latency from the accept edge to out_valid high:
  - ADD/SUB/NOP/div-by-zero: 1 cycle.
  - MUL/DIV: WIDTH+1 cycles.
  - Throughput is at most one operation per latency+1 cycles.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
  - MUL gives the full 2*WIDTH product split across {result_hi, result_lo}.
  - DIV unsigned: result_lo = a / b, result_hi = a % b.
  - DIV with b == 0: result_lo all ones, result_hi = a, div_by_zero 1.
  - div_by_zero is 0 for every other operation.
- zero reflects result_lo only and is registered together with it.
- Inputs are ignored while not IDLE; changes to a, b or op during BUSY do not affect the result.

Optional Feature:
- Macro: MDU_SIGNED_EN.
- Defined, is_signed = 1:
  - MUL/DIV take operand magnitudes, iterate unsigned, then negate the result as required.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - MIN / -1 gives result_lo = MIN, result_hi = 0.
  - Signed div-by-zero: result_lo all ones, result_hi = a.
  - Latency rises to WIDTH+2 for MUL/DIV, one extra fix-up cycle in BUSY.
  - ADD/SUB are unaffected.
- Not defined: is_signed is ignored; all MUL/DIV are unsigned; latencies as stated above.

Test Plan:
- Reset and idle (WIDTH=32): assert rst 2 cycles, then hold in_valid 0 -> in_ready 1, out_valid 0, all outputs 0; rst asserted mid-DIV returns to IDLE next cycle with out_valid 0.
- ADD/SUB (WIDTH=32): ADD a=0xFFFFFFFF, b=1 -> out_valid 1 cycle after accept, result_lo 0, zero 1, result_hi 0; SUB a=5, b=7 -> result_lo 0xFFFFFFFE.
- MUL (WIDTH=32): a=0xFFFFFFFF, b=0xFFFFFFFF -> after 33 cycles, hi 0xFFFFFFFE, lo 0x00000001; in_ready 0 throughout.
- DIV and div-by-zero (WIDTH=32): a=100, b=7 -> lo 14, hi 2; a=9, b=0 -> 1 cycle, lo 0xFFFFFFFF, hi 9, div_by_zero 1.
- Backpressure (WIDTH=8): MUL 13*11, out_ready held 0 for 5 cycles -> outputs stable {hi 0x00, lo 0x8F}; a new in_valid is refused; accepted on the cycle after out_ready.
- Signed (MDU_SIGNED_EN, WIDTH=8): DIV -7/2 -> lo 0xFD, hi 0xFF; DIV 0x80/0xFF -> lo 0x80, hi 0; MUL -3*5 -> {hi 0xFF, lo 0xF1}.
